interrupt_controller: RTL
=========================

# interrupt_controller

Front-end for the core's `interrupt` input. It synchronises an asynchronous external request pin and latches it as pending. When the pipeline is at a safe boundary it fires a one-cycle interrupt to the core, holds fetch while the pipeline drains, then sequences three stack-push slots (PC high, PC low, flags). It blocks nesting until the core retires RTI, and sits between the board-level IRQ pin and the processor top.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `irq_pin`; legal values are 2 or more.
- `DRAIN_CYCLES`, 3: cycles fetch is held after `int_out` before the first push slot; legal values are 1 or more.
- `MISS_W`, 8: width of the missed-request counter.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_pin`  in  1  external request, asynchronous to `clk`; rising edge means request.
- `irq_enable`  in  1  global interrupt enable.
- `core_busy`  in  1  high while a branch flush is active or a two-word instruction sits in decode.
- `rti_retire`  in  1  one-cycle pulse when RTI reaches writeback.
- `int_out`  out  1  interrupt pulse to the core's fetch stage.
- `fetch_hold`  out  1  stall request to fetch.
- `push_valid`  out  1  a stack-push slot is active this cycle.
- `push_sel`  out  2  push slot: 0 = PC[31:16], 1 = PC[15:0], 2 = saved flags.
- `in_service`  out  1  ISR running; nesting is blocked.
- `pending`  out  1  request latched and not yet accepted.
- `missed_count`  out  MISS_W  saturating count of coalesced requests.

## Operation
- Edge detect: `edge = s[SYNC_STAGES-1] & ~prev`, where `prev` is a register of the last synchroniser stage.
- Pending latch:
  - `edge` sets `pending`.
  - Acceptance clears it.
  - If `edge` and acceptance occur in the same cycle, set wins.
- Missed count: `edge` while `pending`=1 and not being cleared increments `missed_count`. It saturates at 2^MISS_W-1 and never wraps.
- FSM states: IDLE, DRAIN, PUSH, SERVICE.
  - **IDLE → DRAIN** when `pending & irq_enable & ~core_busy` (this is acceptance). On this transition: `int_out` is high for exactly one cycle, `fetch_hold` goes high, `pending` clears, and the drain counter loads DRAIN_CYCLES-1.
  - **DRAIN**: decrement the counter each cycle. At 0, go to PUSH with slot index 0.
  - **PUSH**: `push_valid`=1 for three consecutive cycles with `push_sel` = 0, 1, 2. After slot 2, go to SERVICE. `fetch_hold` deasserts on entry to SERVICE.
  - **SERVICE**: `in_service`=1. New edges still set `pending` but are not accepted. `rti_retire` → IDLE.
- `rti_retire` outside SERVICE is ignored.
- `irq_enable` or `core_busy` changing during DRAIN or PUSH does not abort the sequence.
- `irq_enable` low in IDLE: `pending` is retained and accepted later.
- All outputs are registered; there are no combinational input-to-output paths.

## Timing
- Reset asserted, asynchronously: state = IDLE; all outputs 0; synchroniser, `prev`, drain counter and `missed_count` all 0.
- Reset mid-sequence: same result, immediately.
- First acceptance possible on the first edge after reset deasserts.
- Latency: `irq_pin` first sampled high at edge k → `pending`=1 after edge k+SYNC_STAGES → `int_out`=1 after edge k+SYNC_STAGES+1. This assumes IDLE, enabled and not busy; with the default it is 3 cycles.
- `fetch_hold` is high for DRAIN_CYCLES+3 cycles, starting in the same cycle as `int_out`.
- `push_valid` is high in cycles DRAIN_CYCLES+1 through DRAIN_CYCLES+3 relative to the `int_out` cycle.
- `in_service` rises in the cycle after the last push slot. It falls in the cycle after `rti_retire` is sampled.
- Back-to-back: with `pending` set during SERVICE, the next `int_out` comes 2 cycles after `rti_retire`. That is one IDLE cycle followed by acceptance, giving a minimum one-cycle gap.
- `irq_pin` pulses shorter than one clock period may be lost. Pulses of at least 2 periods are guaranteed to be captured.

## Structure
- Shared package `interrupt_pkg` holds:
  - FSM state enum `int_state_t`.
  - `PUSH_PC_HI`=2'd0, `PUSH_PC_LO`=2'd1, `PUSH_FLAGS`=2'd2.
  - `NUM_PUSH_SLOTS`=3.
- Sub-module `irq_synchronizer` (params `SYNC_STAGES`) contains the synchroniser chain, the `prev` register and the `edge` output. It is reset by `reset` to 0.
- The top block contains the FSM, drain counter, pending latch and missed counter.

## Test plan
- Single request: `irq_pin` held high 4 cycles with defaults.
  - `int_out` pulses 3 cycles after the first sample.
  - `fetch_hold` is high 6 cycles.
  - `push_sel` sequence 0, 1, 2 in cycles 4-6.
  - `in_service`=1 until 1 cycle after `rti_retire`.
- `core_busy` high for 5 cycles while `pending`=1 → `int_out` fires exactly 1 cycle after `core_busy` falls.
- `irq_enable`=0 with a request → `pending` stays 1 and there is no `int_out`. Set `irq_enable`=1 → `int_out` on the next cycle.
- Three edges during SERVICE:
  - `pending`=1 and `missed_count`=2.
  - After `rti_retire`, a second `int_out` comes 2 cycles later.
  - With MISS_W=2, repeated edges hold `missed_count` at 3.
- Reset asserted in the 2nd PUSH cycle → all outputs 0 immediately. After release, the FSM is IDLE and the `rti_retire` pulse is ignored.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt front-end: FSM states and
// the ordering of the stack-push slots.
package interrupt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH,
    ST_SERVICE
  } int_state_t;

  localparam logic [1:0] PUSH_PC_HI = 2'd0;
  localparam logic [1:0] PUSH_PC_LO = 2'd1;
  localparam logic [1:0] PUSH_FLAGS = 2'd2;

  localparam int NUM_PUSH_SLOTS = 3;

endpackage

// File: rtl/irq_synchronizer.sv
// Multi-flop synchroniser for the asynchronous IRQ pin with a rising-edge
// detector on the synchronised output.
module irq_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_pin,
  output logic irq_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign irq_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front-end: latches synchronised IRQ edges, accepts them at a safe
// pipeline boundary, drains fetch, sequences the stack pushes and blocks nesting.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int MISS_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq_pin,
  input  logic              irq_enable,
  input  logic              core_busy,
  input  logic              rti_retire,
  output logic              int_out,
  output logic              fetch_hold,
  output logic              push_valid,
  output logic [1:0]        push_sel,
  output logic              in_service,
  output logic              pending,
  output logic [MISS_W-1:0] missed_count
);

  localparam int               CNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [1:0]       LAST_SLOT = 2'(NUM_PUSH_SLOTS - 1);

  int_state_t        r_state, w_next_state;
  logic [CNT_W-1:0]  r_drain_cnt, w_next_cnt;
  logic [1:0]        r_slot, w_next_slot;
  logic              r_pending;
  logic [MISS_W-1:0] r_missed;
  logic              r_int_out, r_fetch_hold, r_push_valid, r_in_service;
  logic [1:0]        r_push_sel;
  logic              w_edge, w_accept;

  irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .irq_pin  (irq_pin),
    .irq_edge (w_edge)
  );

  assign w_accept = (r_state == ST_IDLE) & r_pending & irq_enable & ~core_busy;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_drain_cnt;
    w_next_slot  = r_slot;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_DRAIN;
          w_next_cnt   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_next_state = ST_PUSH;
          w_next_slot  = PUSH_PC_HI;
        end else begin
          w_next_cnt = r_drain_cnt - CNT_W'(1);
        end
      end
      ST_PUSH: begin
        if (r_slot == LAST_SLOT) w_next_state = ST_SERVICE;
        else                     w_next_slot  = r_slot + 2'd1;
      end
      ST_SERVICE: begin
        if (rti_retire) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_drain_cnt  <= '0;
      r_slot       <= PUSH_PC_HI;
      r_pending    <= 1'b0;
      r_missed     <= '0;
      r_int_out    <= 1'b0;
      r_fetch_hold <= 1'b0;
      r_push_valid <= 1'b0;
      r_push_sel   <= PUSH_PC_HI;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_drain_cnt  <= w_next_cnt;
      r_slot       <= w_next_slot;
      r_int_out    <= w_accept;
      r_fetch_hold <= (w_next_state == ST_DRAIN) || (w_next_state == ST_PUSH);
      r_push_valid <= (w_next_state == ST_PUSH);
      r_push_sel   <= (w_next_state == ST_PUSH) ? w_next_slot : PUSH_PC_HI;
      r_in_service <= (w_next_state == ST_SERVICE);
      // A new edge beats a simultaneous acceptance.
      if (w_edge)        r_pending <= 1'b1;
      else if (w_accept) r_pending <= 1'b0;
      if (w_edge && r_pending && !w_accept && (r_missed != '1))
        r_missed <= r_missed + MISS_W'(1);
    end
  end

  assign int_out      = r_int_out;
  assign fetch_hold   = r_fetch_hold;
  assign push_valid   = r_push_valid;
  assign push_sel     = r_push_sel;
  assign in_service   = r_in_service;
  assign pending      = r_pending;
  assign missed_count = r_missed;

endmodule
